// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: hunts for SOF, parses LEN + payload (+ CHK), buffers the frame and replays only good frames.
// Define UART_FRAME_CHECKSUM_EN to expect and verify the trailing CHK byte; undefined builds frame without it.
`timescale 1ns/1ps
module uart_frame_decoder #(
    parameter int         MAX_LEN        = 64,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in_data,
    input  logic        byte_in_valid,
    output logic        byte_in_ready,
    output logic [7:0]  frm_out_data,
    output logic        frm_out_valid,
    output logic        frm_out_last,
    input  logic        frm_out_ready,
    output logic        err_length,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic [15:0] drop_count
);
    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_DATA, S_CHK, S_EMIT} state_t;

    state_t           state, state_nxt;
    logic [7:0]       frame_buf [MAX_LEN];
    logic [IDX_W-1:0] len, wr_idx, rd_idx;
    logic [CNT_W-1:0] idle_cnt;
    logic             accept, emit_hs, in_frame, idle_expired, len_bad, data_done;
    logic             ev_len, ev_chk, ev_to;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]       sum;
    logic             chk_ok;
`endif

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept       = byte_in_valid && byte_in_ready;
    assign emit_hs      = frm_out_valid && frm_out_ready;
    assign in_frame     = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign idle_expired = in_frame && !accept && (idle_cnt == IDLE_MAX);
    assign len_bad      = (byte_in_data == 8'd0) || ({24'd0, byte_in_data} > 32'(MAX_LEN));
    assign data_done    = (wr_idx == len - IDX_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HUNT: if (accept && byte_in_data == SOF_BYTE) state_nxt = S_LEN;
            S_LEN: begin
                if (accept)            state_nxt = len_bad ? S_HUNT : S_DATA;
                else if (idle_expired) state_nxt = S_HUNT;
            end
            S_DATA: begin
`ifdef UART_FRAME_CHECKSUM_EN
                if (accept && data_done) state_nxt = S_CHK;
`else
                if (accept && data_done) state_nxt = S_EMIT;
`endif
                else if (idle_expired)   state_nxt = S_HUNT;
            end
`ifdef UART_FRAME_CHECKSUM_EN
            S_CHK: begin
                if (accept)            state_nxt = chk_ok ? S_EMIT : S_HUNT;
                else if (idle_expired) state_nxt = S_HUNT;
            end
`endif
            S_EMIT: if (emit_hs && frm_out_last) state_nxt = S_HUNT;
            default: state_nxt = S_HUNT;
        endcase
    end

    always_comb begin
        byte_in_ready = (state != S_EMIT);
        frm_out_valid = (state == S_EMIT);
        frm_out_data  = frm_out_valid ? frame_buf[rd_idx[ADDR_W-1:0]] : 8'h00;
        frm_out_last  = frm_out_valid && (rd_idx == len - IDX_W'(1));
        ev_len        = (state == S_LEN) && accept && len_bad;
        ev_to         = idle_expired;
        ev_chk        = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        ev_chk        = (state == S_CHK) && accept && !chk_ok;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_length   <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            drop_count   <= 16'd0;
        end else begin
            err_length   <= ev_len;
            err_checksum <= ev_chk;
            err_timeout  <= ev_to;
            if (ev_len || ev_chk || ev_to) drop_count <= sat_inc16(drop_count);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len      <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            idle_cnt <= '0;
        end else begin
            if (!in_frame || accept) idle_cnt <= '0;
            else                     idle_cnt <= idle_cnt + CNT_W'(1);

            if (state == S_LEN && accept) begin
                len    <= IDX_W'(byte_in_data);
                wr_idx <= '0;
            end else if (state == S_DATA && accept) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end

            if (state != S_EMIT) rd_idx <= '0;
            else if (emit_hs)    rd_idx <= rd_idx + IDX_W'(1);
        end
    end

    // Payload storage and running sum carry no reset; a dropped frame leaves them as don't-care.
    always_ff @(posedge clk) begin
        if (state == S_DATA && accept) frame_buf[wr_idx[ADDR_W-1:0]] <= byte_in_data;
    end

`ifdef UART_FRAME_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (state == S_LEN && accept)       sum <= byte_in_data;
        else if (state == S_DATA && accept) sum <= sum + byte_in_data;
    end

    assign chk_ok = ((sum + byte_in_data) == 8'h00);
`endif

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder; expectations adapt to UART_FRAME_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_frame_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in_data;
    logic        byte_in_valid;
    logic        byte_in_ready;
    logic [7:0]  frm_out_data;
    logic        frm_out_valid;
    logic        frm_out_last;
    logic        frm_out_ready;
    logic        err_length, err_checksum, err_timeout;
    logic [15:0] drop_count;

    uart_frame_decoder #(.MAX_LEN(64), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .byte_in_data(byte_in_data), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
        .frm_out_data(frm_out_data), .frm_out_valid(frm_out_valid), .frm_out_last(frm_out_last),
        .frm_out_ready(frm_out_ready),
        .err_length(err_length), .err_checksum(err_checksum), .err_timeout(err_timeout),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int n_len = 0, n_chk = 0, n_to = 0, n_multi = 0, n_unstable = 0, n_rdy_emit = 0;
    int rd_ptr = 0;
    int exp_drop = 0;
    int budget;
    logic        hold_pending = 1'b0;
    logic [8:0]  held;
    logic [8:0]  out_q[$];
    logic [8:0]  exp_q[$];
    logic [7:0]  tx[$];

    // Observe on the falling edge: record completed output handshakes, stalls, pulses.
    always @(negedge clk) begin
        if (frm_out_valid) begin
            if (hold_pending && {frm_out_last, frm_out_data} != held) n_unstable++;
            if (byte_in_ready) n_rdy_emit++;
            if (frm_out_ready) out_q.push_back({frm_out_last, frm_out_data});
            hold_pending = !frm_out_ready;
            held = {frm_out_last, frm_out_data};
        end else begin
            hold_pending = 1'b0;
        end
        if (err_length)   n_len++;
        if (err_checksum) n_chk++;
        if (err_timeout)  n_to++;
        if (int'(err_length) + int'(err_checksum) + int'(err_timeout) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        byte_in_data  = b;
        byte_in_valid = 1'b1;
        @(negedge clk);
        while (!byte_in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_in_ready) check("in_ready_wait", 32'(byte_in_ready), 32'd1);
        @(posedge clk);
        #1;
        byte_in_valid = 1'b0;
    endtask

    task automatic send_tx();
        for (int i = 0; i < tx.size(); i++) send_byte(tx[i]);
    endtask

    task automatic expect_out(input string tag);
        int n = exp_q.size();
        int waited = 0;
        while (out_q.size() < rd_ptr + n && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(out_q.size() - rd_ptr), 32'(n));
        for (int i = 0; i < n; i++)
            if (rd_ptr + i < out_q.size())
                check({tag, "_byte"}, 32'(out_q[rd_ptr + i]), 32'(exp_q[i]));
        rd_ptr = out_q.size();
    endtask

    initial begin
        rst_n = 1'b0; byte_in_data = 8'h00; byte_in_valid = 1'b0; frm_out_ready = 1'b1;
        #3;
        check("rst_in_ready",  32'(byte_in_ready), 32'd1);
        check("rst_out_valid", 32'(frm_out_valid), 32'd0);
        check("rst_out_last",  32'(frm_out_last), 32'd0);
        check("rst_out_data",  32'(frm_out_data), 32'd0);
        check("rst_err",       32'({err_length, err_checksum, err_timeout}), 32'd0);
        check("rst_drop",      32'(drop_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Good frame: 03+11+22+33+97 = 0x100
`ifdef UART_FRAME_CHECKSUM_EN
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
`else
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
`endif
        send_tx();
        check("lat_valid",    32'(frm_out_valid), 32'd1);
        check("lat_data",     32'(frm_out_data), 32'h11);
        check("emit_in_rdy",  32'(byte_in_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("good_last",    32'({frm_out_last, frm_out_data}), 32'h133);
        @(posedge clk); #1;
        check("reaccept_rdy", 32'(byte_in_ready), 32'd1);
        check("reaccept_vld", 32'(frm_out_valid), 32'd0);
`ifndef UART_FRAME_CHECKSUM_EN
        tx = '{8'h97};
        send_tx();
`endif
        exp_q = '{9'h011, 9'h022, 9'h133};
        expect_out("good");
        check("good_errs", 32'(n_len + n_chk + n_to), 32'd0);
        check("good_drop", 32'(drop_count), 32'd0);

        // Corrupted checksum, then the same good frame again
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        send_tx();
`ifdef UART_FRAME_CHECKSUM_EN
        exp_q.delete();
        exp_drop = 1;
        expect_out("badchk");
        check("badchk_pulses", 32'(n_chk), 32'd1);
`else
        exp_q = '{9'h011, 9'h022, 9'h133};
        expect_out("badchk");
        check("badchk_pulses", 32'(n_chk), 32'd0);
`endif
        check("badchk_drop", 32'(drop_count), 32'(exp_drop));
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_tx();
        exp_q = '{9'h011, 9'h022, 9'h133};
        expect_out("after_bad");

        // Illegal lengths 0 and MAX_LEN+1
        tx = '{8'hA5, 8'h00, 8'hA5, 8'h41};
        send_tx();
        exp_q.delete();
        expect_out("badlen");
        exp_drop += 2;
        check("badlen_pulses", 32'(n_len), 32'd2);
        check("badlen_drop",   32'(drop_count), 32'(exp_drop));

        // Timeout fires on the 50th idle clock
        tx = '{8'hA5, 8'h02, 8'h11};
        send_tx();
        repeat (49) @(posedge clk);
        #1;
        check("to_early", 32'(err_timeout), 32'd0);
        @(posedge clk); #1;
        check("to_pulse", 32'(err_timeout), 32'd1);
        exp_drop += 1;
        check("to_drop", 32'(drop_count), 32'(exp_drop));
        @(posedge clk); #1;
        check("to_pulse_end", 32'(err_timeout), 32'd0);
        check("to_count", 32'(n_to), 32'd1);
        tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
        send_tx();
        exp_q = '{9'h010, 9'h120};
        expect_out("after_to");

        // Byte landing on the expiry cycle beats the timeout: 02+11+22+CB = 0x100
        tx = '{8'hA5, 8'h02, 8'h11};
        send_tx();
        repeat (49) @(posedge clk);
        #1;
`ifdef UART_FRAME_CHECKSUM_EN
        tx = '{8'h22, 8'hCB};
`else
        tx = '{8'h22};
`endif
        send_tx();
        exp_q = '{9'h011, 9'h122};
        expect_out("to_win");
        check("to_win_count", 32'(n_to), 32'd1);
        check("to_win_drop",  32'(drop_count), 32'(exp_drop));

        // Noise then a 4-byte frame under alternating backpressure: 04+01+02+03+04+F2 = 0x100
        tx = '{8'h00, 8'hFF, 8'h5A};
        send_tx();
        frm_out_ready = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        tx = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
`else
        tx = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
`endif
        send_tx();
        check("bp_valid",    32'(frm_out_valid), 32'd1);
        check("bp_in_ready", 32'(byte_in_ready), 32'd0);
        budget = 0;
        while (out_q.size() < rd_ptr + 4 && budget < 100) begin
            @(posedge clk); #1;
            frm_out_ready = ~frm_out_ready;
            budget++;
        end
        frm_out_ready = 1'b1;
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h104};
        expect_out("bp");
        check("bp_stable",      32'(n_unstable), 32'd0);
        check("bp_no_upstream", 32'(n_rdy_emit), 32'd0);
        check("bp_drop",        32'(drop_count), 32'(exp_drop));

        // Asynchronous reset while the third byte is presented: 04+0A+0B+0C+0D+CE = 0x100
`ifdef UART_FRAME_CHECKSUM_EN
        tx = '{8'hA5, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hCE};
`else
        tx = '{8'hA5, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
`endif
        send_tx();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_data", 32'({frm_out_valid, frm_out_data}), 32'h10C);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(frm_out_valid), 32'd0);
        check("arst_last",  32'(frm_out_last), 32'd0);
        check("arst_data",  32'(frm_out_data), 32'd0);
        check("arst_drop",  32'(drop_count), 32'd0);
        check("arst_rdy",   32'(byte_in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q = '{9'h00A, 9'h00B};
        expect_out("pre_rst");
        tx = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
        send_tx();
        exp_q = '{9'h010, 9'h120};
        expect_out("post_rst");
        check("post_rst_drop", 32'(drop_count), 32'd0);
        check("err_exclusive", 32'(n_multi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-stream framer sitting directly downstream of the UART receiver. It consumes received bytes over a valid/ready handshake, hunts for a start-of-frame marker, and parses a length-prefixed, checksummed frame into an internal buffer. Only frames that pass all checks are replayed to the debug command logic as a byte stream with an end-of-frame marker. Malformed, corrupted or stalled frames are dropped, flagged and counted.

## Interface
- `MAX_LEN`, default 64: maximum payload bytes per frame; sets the buffer depth.
- `SOF_BYTE`, default 8'hA5: start-of-frame marker.
- `TIMEOUT_CYCLES`, default 100000: maximum idle clocks between bytes inside a frame.
- `clk` in 1: single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `byte_in_data` in 8: received byte from the UART receiver.
- `byte_in_valid` in 1: `byte_in_data` is valid.
- `byte_in_ready` out 1: decoder accepts a byte this cycle.
- `frm_out_data` out 8: payload byte.
- `frm_out_valid` out 1: `frm_out_data` is valid.
- `frm_out_last` out 1: current byte is the final payload byte.
- `frm_out_ready` in 1: downstream accepts the byte.
- `err_length` out 1: one-cycle pulse on an illegal LEN.
- `err_checksum` out 1: one-cycle pulse on a checksum mismatch.
- `err_timeout` out 1: one-cycle pulse on an inter-byte timeout.
- `drop_count` out 16: count of dropped frames, saturates at 16'hFFFF.

## Operation
- Wire format: SOF, LEN, then LEN payload bytes, then CHK.
- Frame is good when (LEN + sum of payload + CHK) mod 256 == 0.
- A byte transfers when `byte_in_valid && byte_in_ready`.
- A payload byte transfers when `frm_out_valid && frm_out_ready`.
- `byte_in_ready` = 1 in HUNT, LEN, DATA and CHK; 0 in EMIT.
- Upstream is never accepted while a frame is being replayed.
- States:
  - HUNT: accept and discard every byte except `SOF_BYTE`. On SOF go to LEN.
  - LEN: accept L.
    - L==0 or L>`MAX_LEN`: pulse `err_length`, drop, go to HUNT.
    - Otherwise latch L, set sum=L, set wr_idx=0, go to DATA.
  - DATA: per accepted byte, write buf[wr_idx], add the byte to sum (8-bit wrap), increment wr_idx. After byte L-1, go to CHK.
  - CHK: accept CHK.
    - (sum+CHK)[7:0]==0: go to EMIT with rd_idx=0.
    - Otherwise pulse `err_checksum`, drop, go to HUNT.
  - EMIT: `frm_out_valid`=1 and `frm_out_data`=buf[rd_idx]. `frm_out_last`=1 when rd_idx==L-1. Each handshake increments rd_idx. Handshake on the last byte goes to HUNT.
- A SOF value seen inside LEN, DATA or CHK is ordinary data; there is no resynchronisation mid-frame.
- Timeout:
  - Idle counter runs in LEN, DATA and CHK. It clears on every accepted byte and on state entry.
  - If the counter reaches `TIMEOUT_CYCLES`-1 with no byte accepted that cycle: pulse `err_timeout`, drop, go to HUNT.
  - A byte accepted in that same cycle wins; no timeout fires.
  - No timeout in HUNT or EMIT.
- Drop: `drop_count` increments by 1 (saturating), the partial frame is discarded, and the buffer contents are don't-care.

## Timing
- Reset values:
  - State HUNT, so `byte_in_ready`=1.
  - `frm_out_valid`=0, `frm_out_last`=0, `frm_out_data`=0.
  - All `err_*`=0 and `drop_count`=0.
- `rst_n` assertion mid-frame or mid-EMIT clears all of the above immediately (asynchronous). No partial frame survives.
- Latency: `frm_out_valid` rises on the cycle after the CHK handshake, or after the last DATA handshake when checksum is compiled out.
- EMIT throughput is 1 byte/clk while `frm_out_ready`=1.
- `frm_out_data` and `frm_out_last` hold stable while valid && !ready.
- The decoder re-accepts input in the cycle after the final output handshake.
- Error pulses are registered, last exactly 1 cycle, and are mutually exclusive.
- `drop_count` updates in the same cycle as the error pulse.
- Index widths: $clog2(`MAX_LEN`+1). Idle counter width: $clog2(`TIMEOUT_CYCLES`).

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined:
  - CHK byte is expected and verified as described above.
- `UART_FRAME_CHECKSUM_EN` undefined:
  - Frame is SOF, LEN, payload only. CHK state and sum logic are removed.
  - DATA goes to EMIT after byte L-1.
  - `err_checksum` is tied 0.

## Test plan
- Good frame: A5 03 11 22 33 97 -> output 11, 22, 33 with last on 33. No error pulses, `drop_count`=0.
- Bad checksum: A5 03 11 22 33 98 -> no output, `err_checksum` pulses once, `drop_count`=1. Next good frame passes unchanged.
- Illegal length: A5 00, then A5 41 (`MAX_LEN`=64) -> two `err_length` pulses, `drop_count`=2, no output.
- Timeout (`TIMEOUT_CYCLES`=50): A5 02 11, then 50 idle clocks -> one `err_timeout`, `drop_count`=1. A good frame sent afterwards emits correctly.
- Noise and backpressure:
  - Stimulus: 00 FF 5A, then a good 4-byte frame, with `frm_out_ready` toggling every cycle.
  - Required: noise ignored, payload emitted in order, data held stable while stalled, `byte_in_ready`=0 throughout EMIT.
- Reset mid-EMIT: drop `rst_n` after the 2nd output byte -> `frm_out_valid`=0 asynchronously, `drop_count`=0. A good frame after release emits correctly.
